sync_fifo_flags: RTL
====================

Name: sync_fifo_flags

Overview:
- Parametrised successor of the team's basic synchronous FIFO.
- Adds arbitrary (non-power-of-two) depth, a live occupancy count, programmable almost-full/almost-empty flags, a selectable first-word-fall-through (FWFT) read mode, and sticky overflow/underflow error flags.
- Single clock domain; used as the standard buffer between producer and consumer blocks.

Parameters:
- FIFO_WIDTH, 8, data word width in bits (≥1).
- FIFO_DEPTH, 8, number of entries (≥2; need not be a power of two).
- AFULL_THRESH, FIFO_DEPTH-2, Almost_Full asserts when Count ≥ this value (1..FIFO_DEPTH).
- AEMPTY_THRESH, 2, Almost_Empty asserts when Count ≤ this value (0..FIFO_DEPTH-1).
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- Data_in  in  FIFO_WIDTH  write data.
- Wr_Req  in  1  write request.
- Rd_Req  in  1  read request (FWFT: pop the head entry).
- Clr_Err  in  1  clears Overflow/Underflow.
- Data_out  out  FIFO_WIDTH  read data.
- Rd_Valid  out  1  Data_out carries newly read data.
- Full  out  1  Count == FIFO_DEPTH.
- Empty  out  1  Count == 0.
- Almost_Full  out  1  Count ≥ AFULL_THRESH.
- Almost_Empty  out  1  Count ≤ AEMPTY_THRESH.
- Count  out  $clog2(FIFO_DEPTH+1)  current occupancy.
- Overflow  out  1  sticky: write attempted while Full.
- Underflow  out  1  sticky: read attempted while Empty.

Behaviour:
- Reset: synchronous, active-high (RST sampled on CLK rising edge).
  - Pointers, Count and Data_out clear to 0.
  - Rd_Valid, Full, Overflow and Underflow clear to 0.
  - Empty and Almost_Empty go to 1; Almost_Full goes to 0.
  - Memory contents are not cleared.
  - RST mid-operation discards all stored data on that edge and overrides every other input.
- Write accept: wr_en = Wr_Req & !Full. On accept, mem[wr_ptr] <= Data_in.
- Read accept: rd_en = Rd_Req & !Empty.
- Full/Empty are evaluated on the pre-edge state. A simultaneous read and write while Full accepts only the read; while Empty accepts only the write.
- Pointer wrap: each pointer advances on accept and wraps from FIFO_DEPTH-1 to 0 by explicit compare (not by modulo-2^n overflow).
- Count: +1 on write-only, −1 on read-only, unchanged when both or neither are accepted. Full, Empty, Almost_Full and Almost_Empty are registered compares of the next Count, so they are valid in the same cycle as Count.
- Standard mode (FWFT=0):
  - On rd_en, Data_out <= mem[rd_ptr] and Rd_Valid <= 1 the next cycle (1-cycle latency).
  - Otherwise Rd_Valid <= 0 and Data_out holds its value.
- FWFT mode (FWFT=1):
  - Data_out continuously shows mem[rd_ptr].
  - Rd_Valid = !Empty.
  - A write into an empty FIFO appears on Data_out the cycle after the write edge.
  - rd_en pops the entry; the next entry is visible the following cycle.
  - Data_out is don't-care while Empty.
- Errors:
  - Overflow <= 1 on Wr_Req & Full.
  - Underflow <= 1 on Rd_Req & Empty.
  - Both remain set until RST or Clr_Err.
  - If Clr_Err coincides with a new error event, the flag stays 1 (set wins).
- Ignored requests change no other state.

Test Plan (WIDTH=8, DEPTH=6, AFULL_THRESH=4, AEMPTY_THRESH=1, FWFT=0 unless stated):
- Reset, then write 0x11..0x66 on consecutive cycles:
  - Count steps 1..6.
  - Almost_Empty drops when Count becomes 2.
  - Almost_Full rises at Count 4.
  - Full rises at Count 6.
- While Full, write 0x77 with Rd_Req=0 → Overflow=1, Count stays 6, entry 0x77 is lost. Then assert Clr_Err one cycle → Overflow=0.
- Read 6 times → Data_out = 0x11..0x66, each valid one cycle after its request with Rd_Valid=1; Empty=1 after the 6th read. A 7th read → Underflow=1, Rd_Valid=0.
- Write 4, read 2, then write 4 → pointers wrap past index 5; 6 reads return the correct order. Simultaneous Wr/Rd at Count 3 → Count stays 3 and data order is preserved.
- FWFT=1: write 0xA5 into an empty FIFO → the next cycle Data_out=0xA5 and Rd_Valid=1 with no Rd_Req. Rd_Req pops it → Empty=1.
- Assert RST with Count=4 and Wr_Req=1 → next cycle Count=0, Empty=1, Full=0, error flags 0. The following write/read returns only the new data.

Source files
------------

// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with arbitrary depth, occupancy count, almost-full/empty flags,
// selectable standard / first-word-fall-through read and sticky error flags.
module sync_fifo_flags #(
    parameter int FIFO_WIDTH    = 8,
    parameter int FIFO_DEPTH    = 8,
    parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
    parameter int AEMPTY_THRESH = 2,
    parameter bit FWFT          = 1'b0
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [FIFO_WIDTH-1:0]           Data_in,
    input  logic                            Wr_Req,
    input  logic                            Rd_Req,
    input  logic                            Clr_Err,
    output logic [FIFO_WIDTH-1:0]           Data_out,
    output logic                            Rd_Valid,
    output logic                            Full,
    output logic                            Empty,
    output logic                            Almost_Full,
    output logic                            Almost_Empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] Count,
    output logic                            Overflow,
    output logic                            Underflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

    logic [FIFO_WIDTH-1:0] mem [0:FIFO_DEPTH-1];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_next;
    logic                  full_q;
    logic                  empty_q;
    logic                  wr_en;
    logic                  rd_en;

    // Requests are qualified by the pre-edge flags: a write while full or a read
    // while empty is dropped (and flagged); neither side is ever back-pressured.
    assign wr_en = Wr_Req & ~full_q;
    assign rd_en = Rd_Req & ~empty_q;

    always_comb begin
        count_next = count_q;
        if (wr_en && !rd_en)
            count_next = count_q + CW'(1);
        else if (rd_en && !wr_en)
            count_next = count_q - CW'(1);
    end

    // Flags are registered from the next count so they line up with Count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            Almost_Full  <= 1'b0;
            Almost_Empty <= 1'b1;
            Overflow     <= 1'b0;
            Underflow    <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + PW'(1);
            if (rd_en)
                rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + PW'(1);
            count_q      <= count_next;
            full_q       <= (count_next == DEPTH_C);
            empty_q      <= (count_next == '0);
            Almost_Full  <= (count_next >= AFULL_C);
            Almost_Empty <= (count_next <= AEMPTY_C);
            if (Wr_Req && full_q)
                Overflow <= 1'b1;
            else if (Clr_Err)
                Overflow <= 1'b0;
            if (Rd_Req && empty_q)
                Underflow <= 1'b1;
            else if (Clr_Err)
                Underflow <= 1'b0;
        end
    end

    // Storage is never cleared; reset only blocks a write on that edge.
    always_ff @(posedge CLK) begin
        if (!RST && wr_en)
            mem[wr_ptr] <= Data_in;
    end

    generate
        if (FWFT) begin : g_fwft
            assign Data_out = mem[rd_ptr];
            assign Rd_Valid = ~empty_q;
        end else begin : g_std
            logic [FIFO_WIDTH-1:0] data_q;
            logic                  valid_q;
            always_ff @(posedge CLK) begin
                if (RST) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rd_en;
                    if (rd_en)
                        data_q <= mem[rd_ptr];
                end
            end
            assign Data_out = data_q;
            assign Rd_Valid = valid_q;
        end
    endgenerate

    assign Full  = full_q;
    assign Empty = empty_q;
    assign Count = count_q;

endmodule
